// File: rtl/div_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_if                                                       |
// | Description : Request/response bundle between the execute-stage issue      |
// |               logic (master) and the iterative divider (slave).            |
// |               start_i, div_op_i, dividend_i, divisor_i : request side      |
// |               busy_o, done_o, result_o                 : response side     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface div_if #(
  parameter int DIV_WIDTH = 32
);
  logic                 start_i;
  logic [1:0]           div_op_i;
  logic [DIV_WIDTH-1:0] dividend_i;
  logic [DIV_WIDTH-1:0] divisor_i;
  logic                 busy_o;
  logic                 done_o;
  logic [DIV_WIDTH-1:0] result_o;

  modport master (
    output start_i, div_op_i, dividend_i, divisor_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, div_op_i, dividend_i, divisor_i,
    output busy_o, done_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : divider                                                      |
// | Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.     |
// |               One quotient bit per clock, one sign-fix cycle, one          |
// |               done cycle. Divide-by-zero and signed overflow finish        |
// |               immediately.                                                 |
// |   clk_i  : clock, rising edge                                              |
// |   rst_i  : synchronous active-high reset                                   |
// |   bus    : div_if slave (start/op/operands in, busy/done/result out)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module divider #(
  parameter int DIV_WIDTH = 32
) (
  input  logic   clk_i,
  input  logic   rst_i,
  div_if.slave   bus
);

  localparam int CNT_W = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [DIV_WIDTH-1:0] rem_q,    rem_d;     // partial remainder
  logic [DIV_WIDTH-1:0] quo_q,    quo_d;     // dividend in, quotient out
  logic [DIV_WIDTH-1:0] dsr_q,    dsr_d;     // divisor magnitude
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 op_rem_q, op_rem_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [DIV_WIDTH-1:0] result_q, result_d;

  logic                 w_accept;
  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_div_zero;
  logic                 w_overflow;
  logic [DIV_WIDTH:0]   w_partial;
  logic                 w_ge;
  logic [DIV_WIDTH-1:0] w_diff;
  logic [DIV_WIDTH-1:0] w_quo_fix;
  logic [DIV_WIDTH-1:0] w_rem_fix;

  assign w_accept   = bus.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_signed   = ~bus.div_op_i[0];
  assign w_a_neg    = w_signed & bus.dividend_i[DIV_WIDTH-1];
  assign w_b_neg    = w_signed & bus.divisor_i[DIV_WIDTH-1];
  assign w_div_zero = (bus.divisor_i == '0);
  assign w_overflow = w_signed
                    && (bus.dividend_i == {1'b1, {(DIV_WIDTH-1){1'b0}}})
                    && (bus.divisor_i == '1);

  // Shift the next dividend bit into the remainder; the extra top bit keeps
  // the comparison exact when the remainder's MSB is shifted out.
  assign w_partial = {rem_q, quo_q[DIV_WIDTH-1]};
  assign w_ge      = (w_partial >= {1'b0, dsr_q});
  // When w_ge holds, the difference is below the divisor and fits the low bits.
  assign w_diff    = w_partial[DIV_WIDTH-1:0] - dsr_q;

  assign w_quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign w_rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    op_rem_d  = op_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (w_accept) begin
          op_rem_d = bus.div_op_i[1];
          if (w_div_zero) begin
            result_d = bus.div_op_i[1] ? bus.dividend_i : '1;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else if (w_overflow) begin
            result_d = bus.div_op_i[1] ? '0 : bus.dividend_i;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else begin
            quo_d     = w_a_neg ? -bus.dividend_i : bus.dividend_i;
            dsr_d     = w_b_neg ? -bus.divisor_i  : bus.divisor_i;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = w_a_neg ^ w_b_neg;
            neg_rem_d = w_a_neg;
            state_d   = S_CALC;
            busy_d    = 1'b1;
          end
        end
      end
      S_CALC: begin
        rem_d = w_ge ? w_diff : w_partial[DIV_WIDTH-1:0];
        quo_d = {quo_q[DIV_WIDTH-2:0], w_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_WIDTH-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = op_rem_q ? w_rem_fix : w_quo_fix;
        state_d  = S_DONE;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      op_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      op_rem_q  <= op_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_divider                                                   |
// | Description : Self-checking bench for divider: directed RV32M cases,       |
// |               handshake/reset scenarios and randomized operations          |
// |               against an arithmetic reference model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_divider;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int NORM_LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  div_if #(.DIV_WIDTH(W)) bus ();

  divider #(.DIV_WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RISC-V division semantics from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (op[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (sb == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return op[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic bit ref_fast(input logic [1:0] op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    return (b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one request and wait for done_o. Returns in the DONE cycle (#1 after
  // the edge). lat = edges after acceptance until done seen; busy_n = sampled
  // busy cycles before that. scramble changes operands after acceptance; poke
  // pulses start_i with junk while the divider is working.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit scramble, input bit poke,
                       output logic [W-1:0] res, output int lat, output int busy_n);
    int k;
    bus.start_i    = 1'b1;
    bus.div_op_i   = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    if (scramble) begin
      bus.div_op_i   = 2'($urandom);
      bus.dividend_i = $urandom;
      bus.divisor_i  = $urandom;
    end
    k = 0;
    busy_n = 0;
    while (!bus.done_o && k < 100) begin
      if (bus.busy_o) busy_n++;
      if (poke && k == 5) begin
        bus.start_i    = 1'b1;
        bus.div_op_i   = 2'($urandom);
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom_range(1, 9);
      end
      if (poke && k == 6) bus.start_i = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    lat = k;
    res = bus.result_o;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 0",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    logic [W-1:0] res;
    int lat, bn;
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, res, lat, bn);
    n_cmp++;
    if (res !== 32'd14) begin n_err++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
    n_cmp++;
    if (lat !== NORM_LAT) begin n_err++; $display("FAIL divu_latency: got %0d want %0d", lat, NORM_LAT); end
    n_cmp++;
    if (bn !== NORM_LAT) begin n_err++; $display("FAIL divu_busy_cycles: got %0d want %0d", bn, NORM_LAT); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done_o !== 1'b0 || bus.result_o !== 32'd14) begin
      n_err++;
      $display("FAIL done_pulse_hold: done=%b result=%h want 0 %h", bus.done_o, bus.result_o, 32'd14);
    end
    do_op(OP_REMU, 32'd100, 32'd7, 1'b0, 1'b0, res, lat, bn);
    n_cmp++;
    if (res !== 32'd2) begin n_err++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]   ops [13]  = '{OP_DIV, OP_REM, OP_REM, OP_DIV,
                                OP_DIVU, OP_DIV, OP_REM,
                                OP_DIV, OP_REM, OP_DIVU, OP_DIVU, OP_REMU, OP_REMU};
    logic [W-1:0] as  [13]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                                32'h1234, 32'h1234, 32'h1234,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'h1234};
    logic [W-1:0] bs  [13]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] exp [13]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd3,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234,
                                32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'h1234};
    bit           fast[13]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1};
    logic [W-1:0] res;
    int lat, bn;
    for (int i = 0; i < 13; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, 1'b0, res, lat, bn);
      n_cmp++;
      if (res !== exp[i]) begin
        n_err++;
        $display("FAIL directed_%0d op=%b a=%h b=%h: got %h want %h", i, ops[i], as[i], bs[i], res, exp[i]);
      end
      n_cmp++;
      if (lat !== (fast[i] ? 0 : NORM_LAT) || (fast[i] && bn !== 0)) begin
        n_err++;
        $display("FAIL directed_timing_%0d: lat=%0d busy=%0d want lat %0d", i, lat, bn, fast[i] ? 0 : NORM_LAT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_handshake();
    logic [W-1:0] res;
    int lat, bn;
    do_op(OP_DIVU, 32'd1000, 32'd9, 1'b0, 1'b1, res, lat, bn);
    n_cmp++;
    if (res !== 32'd111 || lat !== NORM_LAT) begin
      n_err++;
      $display("FAIL start_in_calc_ignored: got %h lat %0d want %h lat %0d", res, lat, 32'd111, NORM_LAT);
    end
    @(posedge clk); #1;
    do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, res, lat, bn);
    n_cmp++;
    if (res !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL operand_change_ignored: got %h want %h", res, 32'hFFFF_FFFE);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res;
    int lat, bn;
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, res, lat, bn);
    // Still in the DONE cycle: the next request goes in at the edge ending it.
    do_op(OP_DIV, 32'hFFFF_FF00, 32'd16, 1'b0, 1'b0, res, lat, bn);
    n_cmp++;
    if (res !== 32'hFFFF_FFF0 || lat !== NORM_LAT || bn !== NORM_LAT) begin
      n_err++;
      $display("FAIL back_to_back: got %h lat %0d busy %0d want %h lat %0d busy %0d",
               res, lat, bn, 32'hFFFF_FFF0, NORM_LAT, NORM_LAT);
    end
    do_op(OP_DIVU, 32'd9, 32'd0, 1'b0, 1'b0, res, lat, bn);
    n_cmp++;
    if (res !== 32'hFFFF_FFFF || lat !== 0) begin
      n_err++;
      $display("FAIL back_to_back_fast: got %h lat %0d want %h lat 0", res, lat, 32'hFFFF_FFFF);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] res;
    int lat, bn, seen;
    bus.start_i    = 1'b1;
    bus.div_op_i   = OP_DIVU;
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid_calc: busy=%b done=%b result=%h want 0 0 0",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done_o) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL no_done_after_reset: got %0d pulses want 0", seen); end
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, res, lat, bn);
    n_cmp++;
    if (res !== 32'd14 || lat !== NORM_LAT) begin
      n_err++;
      $display("FAIL fresh_after_reset: got %h lat %0d want %h lat %0d", res, lat, 32'd14, NORM_LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a, b, res, exp;
    int lat, bn, exp_lat;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = '0;
        1:       b = '1;
        2:       b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp     = ref_model(op, a, b);
      exp_lat = ref_fast(op, a, b) ? 0 : NORM_LAT;
      do_op(op, a, b, 1'b0, 1'b0, res, lat, bn);
      n_cmp++;
      if (res !== exp) begin
        n_err++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got %h want %h", i, op, a, b, res, exp);
      end
      n_cmp++;
      if (lat !== exp_lat) begin
        n_err++;
        $display("FAIL random_latency_%0d: got %0d want %0d", i, lat, exp_lat);
      end
      if (i % 3 == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.div_op_i   = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    test_reset();
    test_divu_basic();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
